// File: rtl/axis_stream_checker.sv
// AXI-Stream sink checker for one mesh output port.
// Accepts beats under optional pseudo-random backpressure, tracks packet
// framing, per-source sequence numbers and beat indices, and reports
// packet/error counts plus the first error code seen since reset or clear.
module axis_stream_checker #(
   parameter int TDATA_WIDTH = 32,
   parameter int TDEST_WIDTH = 4,
   parameter int NODE_ID     = 0,
   parameter int NUM_NODES   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   stall_en,
   input  logic                   clear,
   input  logic                   axis_in_tvalid,
   output logic                   axis_in_tready,
   input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
   input  logic                   axis_in_tlast,
   input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
   output logic [15:0]            pkt_count,
   output logic [15:0]            err_count,
   output logic                   err_flag,
   output logic [2:0]             err_code
);

   localparam int                     SRC_W       = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
   localparam logic [TDEST_WIDTH-1:0] NODE_ID_C   = TDEST_WIDTH'(NODE_ID);
   localparam logic [8:0]             NUM_NODES_C = 9'(NUM_NODES);
   localparam logic [7:0]             LFSR_SEED   = 8'hA5;

   typedef enum logic [0:0] {
      ST_WAIT_HEAD = 1'b0,
      ST_IN_PKT    = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic [7:0]      lfsr_r;
   logic            tready_r;
   logic [7:0]      beat_idx_r;
   logic [7:0]      exp_seq_r [NUM_NODES];
   logic [7:0]      head_src_r;
   logic [7:0]      head_seq_r;
   logic [15:0]     pkt_count_r;
   logic [15:0]     err_count_r;
   logic            err_flag_r;
   logic [2:0]      err_code_r;

   logic            xfer_s;
   logic [7:0]      seq_s;
   logic [7:0]      src_s;
   logic [7:0]      idx_s;
   logic            src_legal_s;
   logic [SRC_W-1:0] src_idx_s;
   logic [7:0]      exp_seq_sel_s;
   logic [2:0]      beat_err_s;
   logic            is_head_s;

   // Fibonacci LFSR step, feedback from taps 8,6,5,4.
   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

   assign xfer_s      = axis_in_tvalid && tready_r;
   assign seq_s       = axis_in_tdata[7:0];
   assign src_s       = axis_in_tdata[15:8];
   assign idx_s       = axis_in_tdata[23:16];
   assign src_legal_s = ({1'b0, src_s} < NUM_NODES_C);
   assign src_idx_s   = src_s[SRC_W-1:0];
   assign is_head_s   = (state_r == ST_WAIT_HEAD);

   // Upper tdata bits carry no checked fields.
   if (TDATA_WIDTH > 24) begin : g_spare
      logic unused_tdata_s;
      assign unused_tdata_s = ^axis_in_tdata[TDATA_WIDTH-1:24];
   end

   // Expected sequence for the addressed source; illegal sources read as zero.
   always_comb begin
      exp_seq_sel_s = 8'h00;
      if (src_legal_s) begin
         exp_seq_sel_s = exp_seq_r[src_idx_s];
      end else begin
         exp_seq_sel_s = 8'h00;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_WAIT_HEAD;
      end else if (clear) begin
         state_r <= ST_WAIT_HEAD;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state: a non-last beat opens a packet, a last beat closes it.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_WAIT_HEAD: begin
            if (xfer_s && !axis_in_tlast) begin
               state_next_s = ST_IN_PKT;
            end else begin
               state_next_s = ST_WAIT_HEAD;
            end
         end
         ST_IN_PKT: begin
            if (xfer_s && axis_in_tlast) begin
               state_next_s = ST_WAIT_HEAD;
            end else begin
               state_next_s = ST_IN_PKT;
            end
         end
         default: state_next_s = ST_WAIT_HEAD;
      endcase
   end

   // FSM output: classify the current beat, highest-priority error only.
   always_comb begin
      beat_err_s = 3'd0;
      if (axis_in_tdest != NODE_ID_C) begin
         beat_err_s = 3'd1;
      end else if (!src_legal_s) begin
         beat_err_s = 3'd2;
      end else if (is_head_s && (seq_s != exp_seq_sel_s)) begin
         beat_err_s = 3'd3;
      end else if (!is_head_s && ((src_s != head_src_r) || (seq_s != head_seq_r))) begin
         beat_err_s = 3'd3;
      end else if (idx_s != beat_idx_r) begin
         beat_err_s = 3'd4;
      end else begin
         beat_err_s = 3'd0;
      end
   end

   // Backpressure LFSR and registered tready; clear does not disturb them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r   <= LFSR_SEED;
         tready_r <= 1'b0;
      end else begin
         tready_r <= enable && (!stall_en || lfsr_r[0]);
         if (stall_en) begin
            lfsr_r <= lfsr_step(lfsr_r);
         end else begin
            lfsr_r <= lfsr_r;
         end
      end
   end

   // Expected beat index within the current packet, wrapping at 256.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_idx_r <= 8'h00;
      end else if (clear) begin
         beat_idx_r <= 8'h00;
      end else if (xfer_s) begin
         beat_idx_r <= axis_in_tlast ? 8'h00 : (beat_idx_r + 8'h01);
      end else begin
         beat_idx_r <= beat_idx_r;
      end
   end

   // Head fields captured so continuation beats can be compared against them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_src_r <= 8'h00;
         head_seq_r <= 8'h00;
      end else if (clear) begin
         head_src_r <= 8'h00;
         head_seq_r <= 8'h00;
      end else if (xfer_s && is_head_s) begin
         head_src_r <= src_s;
         head_seq_r <= seq_s;
      end else begin
         head_src_r <= head_src_r;
         head_seq_r <= head_seq_r;
      end
   end

   // Per-source expected sequence; every legal head resyncs to seq+1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NODES; i++) begin
            exp_seq_r[i] <= 8'h00;
         end
      end else if (clear) begin
         for (int i = 0; i < NUM_NODES; i++) begin
            exp_seq_r[i] <= 8'h00;
         end
      end else if (xfer_s && is_head_s && src_legal_s) begin
         exp_seq_r[src_idx_s] <= seq_s + 8'h01;
      end else begin
         exp_seq_r <= exp_seq_r;
      end
   end

   // Saturating packet and error counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_r <= 16'h0000;
         err_count_r <= 16'h0000;
      end else if (clear) begin
         pkt_count_r <= 16'h0000;
         err_count_r <= 16'h0000;
      end else begin
         if (xfer_s && axis_in_tlast && (pkt_count_r != 16'hFFFF)) begin
            pkt_count_r <= pkt_count_r + 16'h0001;
         end else begin
            pkt_count_r <= pkt_count_r;
         end
         if (xfer_s && (beat_err_s != 3'd0) && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
         end else begin
            err_count_r <= err_count_r;
         end
      end
   end

   // Sticky error flag with the code of the first error only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag_r <= 1'b0;
         err_code_r <= 3'd0;
      end else if (clear) begin
         err_flag_r <= 1'b0;
         err_code_r <= 3'd0;
      end else if (xfer_s && (beat_err_s != 3'd0) && !err_flag_r) begin
         err_flag_r <= 1'b1;
         err_code_r <= beat_err_s;
      end else begin
         err_flag_r <= err_flag_r;
         err_code_r <= err_code_r;
      end
   end

   assign axis_in_tready = tready_r;
   assign pkt_count      = pkt_count_r;
   assign err_count      = err_count_r;
   assign err_flag       = err_flag_r;
   assign err_code       = err_code_r;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Self-checking bench for axis_stream_checker: directed vector table,
// reset/backpressure sequences and a randomized run against a packet-level
// reference model.
module tb_axis_stream_checker;

   localparam int NODE_ID   = 0;
   localparam int NUM_NODES = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        stall_en = 1'b0;
   logic        clear = 1'b0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic [31:0] tdata = 32'h0;
   logic        tlast = 1'b0;
   logic [3:0]  tdest = 4'h0;
   logic [15:0] pkt_count;
   logic [15:0] err_count;
   logic        err_flag;
   logic [2:0]  err_code;

   int n_cmp = 0;
   int n_bad = 0;

   axis_stream_checker #(
      .TDATA_WIDTH(32), .TDEST_WIDTH(4), .NODE_ID(NODE_ID), .NUM_NODES(NUM_NODES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .stall_en(stall_en), .clear(clear),
      .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
      .axis_in_tlast(tlast), .axis_in_tdest(tdest),
      .pkt_count(pkt_count), .err_count(err_count), .err_flag(err_flag), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (packet level) ----------------
   logic [7:0] m_lfsr;
   bit         m_ready;
   int         m_pkt, m_err, m_code;
   bit         m_flag;
   int         m_expseq [256];
   int         m_pos;          // beats already received in current packet
   int         m_hsrc, m_hseq;

   function automatic logic [7:0] lfsr_step(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   task automatic model_clear();
      m_pkt = 0; m_err = 0; m_code = 0; m_flag = 0; m_pos = 0;
      m_hsrc = 0; m_hseq = 0;
      for (int i = 0; i < 256; i++) m_expseq[i] = 0;
   endtask

   task automatic model_beat(input int dst, input int src, input int seq, input int idx, input bit lst);
      int code;
      code = 0;
      if (dst != NODE_ID) code = 1;
      else if (src >= NUM_NODES) code = 2;
      else if (m_pos == 0 && seq != m_expseq[src]) code = 3;
      else if (m_pos != 0 && (src != m_hsrc || seq != m_hseq)) code = 3;
      else if (idx != (m_pos % 256)) code = 4;
      if (m_pos == 0) begin
         if (src < NUM_NODES) m_expseq[src] = (seq + 1) % 256;
         m_hsrc = src; m_hseq = seq;
      end
      if (code != 0) begin
         if (m_err < 65535) m_err++;
         if (!m_flag) begin m_flag = 1; m_code = code; end
      end
      if (lst) begin
         if (m_pkt < 65535) m_pkt++;
         m_pos = 0;
      end else begin
         m_pos++;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One clock: model acts on pre-edge inputs, outputs compared #1 after edge.
   task automatic tick(output bit xfer);
      bit nr;
      xfer = tvalid && m_ready;
      @(posedge clk);
      if (clear) model_clear();
      else if (xfer) model_beat(int'(tdest), int'(tdata[15:8]), int'(tdata[7:0]),
                                int'(tdata[23:16]), tlast);
      nr = enable && (!stall_en || m_lfsr[0]);
      if (stall_en) m_lfsr = lfsr_step(m_lfsr);
      m_ready = nr;
      #1;
      check("tready", int'(tready), int'(m_ready));
      check("pkt_count", int'(pkt_count), m_pkt);
      check("err_count", int'(err_count), m_err);
      check("err_flag", int'(err_flag), int'(m_flag));
      check("err_code", int'(err_code), m_code);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_lfsr = 8'hA5; m_ready = 0;
      model_clear();
      #2;
      check("rst_tready", int'(tready), 0);
      check("rst_pkt", int'(pkt_count), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_flag_code", int'({err_flag, err_code}), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_beat(input bit v, input int dst, input int src, input int seq,
                           input int idx, input bit lst);
      tvalid = v;
      tdest  = 4'(dst);
      tdata  = {8'h00, 8'(idx), 8'(src), 8'(seq)};
      tlast  = lst;
   endtask

   typedef struct {
      bit   clr;
      bit   v;
      int   dst, src, seq, idx;
      bit   lst;
      int   e_pkt, e_err, e_flag, e_code;
   } vec_t;

   vec_t vecs [16];

   // generator state for the random phase
   int g_seqs [8];
   int g_pos, g_len, g_src, g_seq, g_dst, g_idx;
   bit g_last;

   initial begin
      bit x;
      int nx, s;

      // clr v  dst src seq idx lst | pkt err flag code
      vecs[0]  = '{0, 1, 0, 1, 0, 0, 1,   1, 0, 0, 0};
      vecs[1]  = '{0, 1, 0, 1, 1, 0, 1,   2, 0, 0, 0};
      vecs[2]  = '{0, 1, 0, 1, 2, 0, 1,   3, 0, 0, 0};
      vecs[3]  = '{0, 0, 5, 6, 9, 7, 1,   3, 0, 0, 0};
      vecs[4]  = '{0, 1, 1, 1, 3, 0, 1,   4, 1, 1, 1};
      vecs[5]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0};
      vecs[6]  = '{0, 1, 0, 1, 0, 0, 1,   1, 0, 0, 0};
      vecs[7]  = '{0, 1, 0, 1, 2, 0, 1,   2, 1, 1, 3};
      vecs[8]  = '{0, 1, 0, 1, 3, 0, 1,   3, 1, 1, 3};
      vecs[9]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0};
      vecs[10] = '{0, 1, 0, 2, 0, 0, 0,   0, 0, 0, 0};
      vecs[11] = '{0, 1, 0, 2, 0, 2, 0,   0, 1, 1, 4};
      vecs[12] = '{0, 1, 0, 2, 0, 2, 1,   1, 1, 1, 4};
      vecs[13] = '{1, 1, 0, 2, 5, 0, 1,   0, 0, 0, 0};
      vecs[14] = '{0, 1, 0, 7, 0, 0, 1,   1, 1, 1, 2};
      vecs[15] = '{0, 1, 0, 3, 0, 0, 1,   2, 1, 1, 2};

      enable = 1'b1; stall_en = 1'b0;
      do_reset();
      set_beat(0, 0, 0, 0, 0, 0);
      tick(x);
      check("tready_after_reset", int'(tready), 1);

      // directed table
      for (int i = 0; i < 16; i++) begin
         clear = vecs[i].clr;
         set_beat(vecs[i].v, vecs[i].dst, vecs[i].src, vecs[i].seq, vecs[i].idx, vecs[i].lst);
         tick(x);
         check($sformatf("vec%0d_pkt", i), int'(pkt_count), vecs[i].e_pkt);
         check($sformatf("vec%0d_err", i), int'(err_count), vecs[i].e_err);
         check($sformatf("vec%0d_flag", i), int'(err_flag), vecs[i].e_flag);
         check($sformatf("vec%0d_code", i), int'(err_code), vecs[i].e_code);
      end
      clear = 1'b0;

      // reset in mid-packet, then a clean single-beat packet
      set_beat(1, 0, 1, 0, 0, 0);
      tick(x);
      do_reset();
      set_beat(1, 0, 1, 0, 0, 1);
      tick(x);
      check("midrst_no_early_accept", int'(pkt_count), 0);
      tick(x);
      set_beat(0, 0, 0, 0, 0, 0);
      check("midrst_pkt", int'(pkt_count), 1);
      check("midrst_err", int'(err_count), 0);
      check("midrst_flag", int'(err_flag), 0);

      // LFSR backpressure with continuous tvalid
      stall_en = 1'b1;
      do_reset();
      nx = 0; s = 0;
      for (int i = 0; i < 256; i++) begin
         set_beat(1, 0, 0, s, 0, 1);
         tick(x);
         if (x) begin nx++; s = (s + 1) % 256; end
         if (i == 0) check("lfsr_first_tready", int'(tready), 1);
         if (i == 1) check("lfsr_second_tready", int'(tready), 0);
      end
      set_beat(0, 0, 0, 0, 0, 0);
      tick(x);
      check("stall_pkt_total", int'(pkt_count), nx);
      check("stall_err_total", int'(err_count), 0);

      // randomized traffic
      for (int i = 0; i < 8; i++) g_seqs[i] = 0;
      g_pos = 0; g_len = 1;
      for (int c = 0; c < 2500; c++) begin
         if (c % 40 == 0) stall_en = ($urandom_range(0, 1) == 1);
         enable = ($urandom_range(0, 15) != 0);
         clear  = ($urandom_range(0, 199) == 0);
         if (g_pos == 0) begin
            g_len = $urandom_range(1, 4);
            g_src = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 7) : $urandom_range(0, NUM_NODES - 1);
            g_seq = g_seqs[g_src] + (($urandom_range(0, 29) == 0) ? 1 : 0);
         end
         g_dst  = ($urandom_range(0, 24) == 0) ? 1 : 0;
         g_idx  = ($urandom_range(0, 24) == 0) ? g_pos + 1 : g_pos;
         g_last = (g_pos == g_len - 1);
         set_beat($urandom_range(0, 3) != 0, g_dst, g_src, g_seq % 256, g_idx, g_last);
         tick(x);
         if (x) begin
            if (g_pos == 0) g_seqs[g_src] = (g_seq + 1) % 256;
            g_pos = g_last ? 0 : g_pos + 1;
         end
      end
      clear = 1'b0;
      set_beat(0, 0, 0, 0, 0, 0);
      tick(x);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
